// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - fetch_state_t : FSM state encoding (IDLE, FETCH, FAULT)
//   - DEFAULT_RESET_PC / DEFAULT_MEM_WORDS : default parameter values
//   - addr_invalid() : misalignment / out-of-range address check
//   - sat_inc16()    : saturating 16-bit increment
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int          DEFAULT_MEM_WORDS = 128;

    // An address is unusable when it is not word aligned or its word index
    // lies beyond the end of the instruction memory. Only addr[31:2] takes
    // part in the range check.
    function automatic logic addr_invalid(input logic [31:0] addr,
                                          input logic [29:0] limit);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= limit);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? 16'hFFFF : (value + 16'd1);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Single-stage instruction fetch with an IF/ID output register, valid/ready
// handshake towards decode, branch redirect, and a terminal fault state for
// misaligned or out-of-range PCs.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous active-high reset
//   imem_addr      out  32  byte address to instruction memory (= PC)
//   imem_instr     in   32  combinational read data for imem_addr
//   branch_valid   in   1   redirect request
//   branch_target  in   32  redirect byte address
//   out_ready      in   1   decode accepts the IF/ID register
//   out_valid      out  1   IF/ID register holds a valid instruction
//   out_instr      out  32  fetched instruction
//   out_pc         out  32  address of out_instr
//   fault          out  1   sticky fetch fault
//   fetch_count    out  16  accepted instructions, saturating
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
    parameter int          MEM_WORDS = fetch_pkg::DEFAULT_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [15:0] fetch_count
);
    import fetch_pkg::*;

    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic         fire_s;

    assign imem_addr = pc_r;
    assign fire_s    = out_valid && out_ready;

    // Fetch FSM: PC, IF/ID register, fault flag and accepted-instruction count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0000_0000;
            out_pc      <= 32'h0000_0000;
            fault       <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    // A fire is counted whatever else happens this cycle,
                    // including when a redirect flushes the register.
                    if (fire_s) begin
                        fetch_count <= sat_inc16(fetch_count);
                    end
                    if (branch_valid) begin
                        out_valid <= 1'b0;
                        if (addr_invalid(branch_target, MEM_LIMIT)) begin
                            state_r <= FAULT;
                            fault   <= 1'b1;
                        end else begin
                            pc_r <= branch_target;
                        end
                    end else if (!out_valid || out_ready) begin
                        // PC runs one past the last word after delivering it;
                        // the fault is raised here, when that PC would be
                        // fetched, so the last instruction is still handed on.
                        if (addr_invalid(pc_r, MEM_LIMIT)) begin
                            state_r   <= FAULT;
                            fault     <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            out_instr <= imem_instr;
                            out_pc    <= pc_r;
                            out_valid <= 1'b1;
                            pc_r      <= pc_r + 32'd4;
                        end
                    end else begin
                        // Stalled: everything holds.
                        out_valid <= out_valid;
                    end
                end
                FAULT: begin
                    out_valid <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state_r   <= FAULT;
                    fault     <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [15:0] fetch_count;

    int checks;
    int failures;

    logic [31:0] mem [0:127];

    instruction_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational instruction memory model
    always_comb begin
        if (imem_addr[31:9] == 23'd0) imem_instr = mem[imem_addr[8:2]];
        else                          imem_instr = 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] word_at(input int idx);
        if (idx == 0) return 32'd11;
        if (idx == 1) return 32'd22;
        if (idx == 2) return 32'd33;
        if (idx == 3) return 32'd44;
        return 32'hA000_0000 | 32'(idx);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; branch_valid = 1'b0; branch_target = 32'd0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b1; branch_valid = 1'b1; branch_target = 32'h80;
        tick();
        rst = 1'b0; branch_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
        checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", out_pc); end
        checks++; if (out_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", out_instr); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0h exp=0", fault); end
        checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", fetch_count); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
        // IDLE cycle: nothing fetched yet
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0h exp=0", out_valid); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL idle_addr got=%0h exp=0", imem_addr); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_i [0:3];
        exp_i[0] = 32'd11; exp_i[1] = 32'd22; exp_i[2] = 32'd33; exp_i[3] = 32'd44;
        do_reset();
        out_ready = 1'b1;
        tick(); // IDLE -> FETCH
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%0h exp=1", k, out_valid); end
            checks++; if (out_pc !== 32'(4 * k)) begin failures++; $display("FAIL seq_pc[%0d] got=%0h exp=%0h", k, out_pc, 4 * k); end
            checks++; if (out_instr !== exp_i[k]) begin failures++; $display("FAIL seq_instr[%0d] got=%0h exp=%0h", k, out_instr, exp_i[k]); end
        end
        tick(); // word 3 accepted
        checks++; if (fetch_count !== 16'd4) begin failures++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
        checks++; if (out_pc !== 32'd16) begin failures++; $display("FAIL seq_pc4 got=%0h exp=10", out_pc); end
    endtask

    task automatic test_stall_and_branch;
        do_reset();
        out_ready = 1'b1;
        tick(); tick(); tick(); tick(); // IDLE, pc0, pc4, pc8
        checks++; if (out_pc !== 32'd8) begin failures++; $display("FAIL stall_setup_pc got=%0h exp=8", out_pc); end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_pc !== 32'd8 || out_instr !== 32'd33 || out_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold[%0d] got pc=%0h instr=%0h v=%0h exp pc=8 instr=21 v=1", k, out_pc, out_instr, out_valid); end
            checks++; if (imem_addr !== 32'd12) begin failures++; $display("FAIL stall_addr[%0d] got=%0h exp=c", k, imem_addr); end
            checks++; if (fetch_count !== 16'd2) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=2", k, fetch_count); end
        end
        // redirect while stalled
        branch_valid = 1'b1; branch_target = 32'h40;
        tick();
        branch_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL br_flush got=%0h exp=0", out_valid); end
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL br_addr got=%0h exp=40", imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== word_at(16)) begin
            failures++; $display("FAIL br_first got v=%0h pc=%0h instr=%0h exp v=1 pc=40 instr=%0h", out_valid, out_pc, out_instr, word_at(16)); end
        checks++; if (fetch_count !== 16'd2) begin failures++; $display("FAIL br_count got=%0d exp=2", fetch_count); end
        // redirect coinciding with a fire still counts
        out_ready = 1'b1; branch_valid = 1'b1; branch_target = 32'h80;
        tick();
        branch_valid = 1'b0;
        checks++; if (fetch_count !== 16'd3) begin failures++; $display("FAIL br_fire_count got=%0d exp=3", fetch_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL br_fire_flush got=%0h exp=0", out_valid); end
    endtask

    task automatic test_fault_branch;
        do_reset();
        out_ready = 1'b1;
        tick(); tick(); // IDLE, pc0 loaded -> PC=4
        branch_valid = 1'b1; branch_target = 32'h42;
        tick();
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault_set got=%0h exp=1", fault); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fault_valid got=%0h exp=0", out_valid); end
        checks++; if (imem_addr !== 32'd4) begin failures++; $display("FAIL fault_pc got=%0h exp=4", imem_addr); end
        checks++; if (fetch_count !== 16'd1) begin failures++; $display("FAIL fault_count got=%0d exp=1", fetch_count); end
        branch_target = 32'h10;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'd4) begin
                failures++; $display("FAIL fault_sticky[%0d] got f=%0h v=%0h a=%0h exp f=1 v=0 a=4", k, fault, out_valid, imem_addr); end
        end
        branch_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fault !== 1'b0 || imem_addr !== 32'd0) begin failures++; $display("FAIL fault_clear got f=%0h a=%0h exp f=0 a=0", fault, imem_addr); end
        // out-of-range but aligned target
        out_ready = 1'b1;
        tick();
        branch_valid = 1'b1; branch_target = 32'h200;
        tick();
        branch_valid = 1'b0;
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault_range got=%0h exp=1", fault); end
    endtask

    task automatic test_end_of_memory;
        do_reset();
        out_ready = 1'b1;
        tick(); // IDLE
        branch_valid = 1'b1; branch_target = 32'h1F8;
        tick();
        branch_valid = 1'b0;
        tick(); // 0x1F8 loaded
        checks++; if (out_pc !== 32'h1F8 || out_valid !== 1'b1) begin failures++; $display("FAIL eom_1f8 got pc=%0h v=%0h exp pc=1f8 v=1", out_pc, out_valid); end
        tick(); // 0x1FC loaded
        checks++; if (out_pc !== 32'h1FC || out_instr !== word_at(127) || out_valid !== 1'b1) begin
            failures++; $display("FAIL eom_1fc got pc=%0h instr=%0h v=%0h exp pc=1fc instr=%0h v=1", out_pc, out_instr, out_valid, word_at(127)); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL eom_early_fault got=%0h exp=0", fault); end
        tick(); // 0x1FC accepted, no fetch at 0x200
        checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL eom_fault got f=%0h v=%0h exp f=1 v=0", fault, out_valid); end
        checks++; if (fetch_count !== 16'd2) begin failures++; $display("FAIL eom_count got=%0d exp=2", fetch_count); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h1FC) begin failures++; $display("FAIL eom_nowrap got v=%0h pc=%0h exp v=0 pc=1fc", out_valid, out_pc); end
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        out_ready = 1'b1;
        tick(); // IDLE
        for (int k = 0; k < 8; k++) tick();
        checks++; if (fetch_count !== 16'd7 || out_pc !== 32'd28) begin failures++; $display("FAIL rms_setup got cnt=%0d pc=%0h exp cnt=7 pc=1c", fetch_count, out_pc); end
        out_ready = 1'b0;
        tick();
        rst = 1'b1; branch_valid = 1'b1; branch_target = 32'h40;
        tick();
        rst = 1'b0; branch_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || fault !== 1'b0 || fetch_count !== 16'd0 || imem_addr !== 32'd0) begin
            failures++; $display("FAIL rms_zero got v=%0h pc=%0h i=%0h f=%0h c=%0d a=%0h exp all 0", out_valid, out_pc, out_instr, fault, fetch_count, imem_addr); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rms_idle got=%0h exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'd11) begin
            failures++; $display("FAIL rms_first got v=%0h pc=%0h i=%0h exp v=1 pc=0 i=b", out_valid, out_pc, out_instr); end
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 128; i++) mem[i] = word_at(i);
        rst = 1'b1; branch_valid = 1'b0; branch_target = 32'd0; out_ready = 1'b0;
        test_reset();
        test_sequential();
        test_stall_and_branch();
        test_fault_branch();
        test_end_of_memory();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
